sf_tester_pattern_checker: RTL and testbench

Read-back verifier for the serial-flash tester. The tester FSM writes pages of a start/increment byte pattern to flash, then reads them back. This block consumes the read-back byte stream, regenerates the expected pattern independently, and reports pass/fail. It reports the error count and the first mismatch to the tester FSM and the display path.

---
 rtl/sf_tester_pattern_checker.sv | 162 ++++++++++++++++
 tb/tb_sf_tester_pattern_checker.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sf_tester_pattern_checker.sv
// Read-back verifier: regenerates the start/increment page pattern and counts mismatches.
// Optional first-mismatch capture is built when SF_CHECKER_FIRST_ERR_CAPTURE_EN is defined.
module sf_tester_pattern_checker #(
    parameter int PARAM_BYTES_PER_PAGE = 256,
    parameter int PARAM_PAGE_COUNT     = 4096,
    parameter int PARAM_ADDR_WIDTH     = 25
) (
    input  logic                        i_clk_40mhz,
    input  logic                        i_rstn_40mhz,
    input  logic                        i_start,
    input  logic [7:0]                  i_pattern_start,
    input  logic [7:0]                  i_pattern_incr,
    input  logic [PARAM_ADDR_WIDTH-1:0] i_start_addr,
    input  logic                        i_abort,
    input  logic                        i_rx_valid,
    input  logic [7:0]                  i_rx_data,
    output logic                        o_rx_ready,
    output logic                        o_busy,
    output logic                        o_done,
    output logic                        o_pass,
    output logic [15:0]                 o_err_count,
    output logic [PARAM_ADDR_WIDTH-1:0] o_byte_count,
    output logic [PARAM_ADDR_WIDTH-1:0] o_first_err_addr,
    output logic [7:0]                  o_first_err_expected,
    output logic [7:0]                  o_first_err_actual
);

    localparam int OFF_W = (PARAM_BYTES_PER_PAGE > 1) ? $clog2(PARAM_BYTES_PER_PAGE) : 1;
    localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(PARAM_BYTES_PER_PAGE - 1);
    localparam logic [PARAM_ADDR_WIDTH-1:0] LAST_IDX =
        PARAM_ADDR_WIDTH'(PARAM_BYTES_PER_PAGE * PARAM_PAGE_COUNT - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t state, state_nxt;

    logic [7:0]       start_lat;
    logic [7:0]       incr_lat;
    logic [7:0]       exp_byte;
    logic [OFF_W-1:0] page_off;
    logic             start_run;
    logic             accept;
    logic             mismatch;
    logic             last_byte;
    logic [15:0]      err_nxt;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge i_clk_40mhz or negedge i_rstn_40mhz) begin
        if (!i_rstn_40mhz) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        start_run  = 1'b0;
        accept     = 1'b0;
        o_rx_ready = 1'b0;
        o_busy     = 1'b0;
        o_done     = 1'b0;
        case (state)
            ST_IDLE: begin
                // start has priority over a coincident abort
                if (i_start) begin
                    start_run = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                o_rx_ready = 1'b1;
                o_busy     = 1'b1;
                if (i_abort) begin
                    state_nxt = ST_IDLE;
                end else if (i_rx_valid) begin
                    accept = 1'b1;
                    if (last_byte) begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                o_done    = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign mismatch  = (i_rx_data != exp_byte);
    assign last_byte = (o_byte_count == LAST_IDX);
    assign err_nxt   = mismatch ? sat_inc(o_err_count) : o_err_count;

    // exp_byte always holds the expected value of the next byte to arrive
    always_ff @(posedge i_clk_40mhz or negedge i_rstn_40mhz) begin
        if (!i_rstn_40mhz) begin
            start_lat    <= 8'd0;
            incr_lat     <= 8'd0;
            exp_byte     <= 8'd0;
            page_off     <= '0;
            o_err_count  <= 16'd0;
            o_byte_count <= '0;
            o_pass       <= 1'b0;
        end else if (start_run) begin
            start_lat    <= i_pattern_start;
            incr_lat     <= i_pattern_incr;
            exp_byte     <= i_pattern_start;
            page_off     <= '0;
            o_err_count  <= 16'd0;
            o_byte_count <= '0;
            o_pass       <= 1'b0;
        end else if (accept) begin
            o_byte_count <= o_byte_count + PARAM_ADDR_WIDTH'(1);
            o_err_count  <= err_nxt;
            if (page_off == LAST_OFF) begin
                page_off <= '0;
                exp_byte <= start_lat;
            end else begin
                page_off <= page_off + OFF_W'(1);
                exp_byte <= exp_byte + incr_lat;
            end
            if (last_byte) begin
                o_pass <= (err_nxt == 16'd0);
            end
        end
    end

`ifdef SF_CHECKER_FIRST_ERR_CAPTURE_EN
    logic [PARAM_ADDR_WIDTH-1:0] addr_lat;

    always_ff @(posedge i_clk_40mhz or negedge i_rstn_40mhz) begin
        if (!i_rstn_40mhz) begin
            addr_lat             <= '0;
            o_first_err_addr     <= '0;
            o_first_err_expected <= 8'd0;
            o_first_err_actual   <= 8'd0;
        end else if (start_run) begin
            addr_lat             <= i_start_addr;
            o_first_err_addr     <= '0;
            o_first_err_expected <= 8'd0;
            o_first_err_actual   <= 8'd0;
        end else if (accept && mismatch && (o_err_count == 16'd0)) begin
            // address arithmetic wraps at the device size
            o_first_err_addr     <= addr_lat + o_byte_count;
            o_first_err_expected <= exp_byte;
            o_first_err_actual   <= i_rx_data;
        end
    end
`else
    logic unused_start_addr;

    assign unused_start_addr    = ^i_start_addr;
    assign o_first_err_addr     = '0;
    assign o_first_err_expected = 8'd0;
    assign o_first_err_actual   = 8'd0;
`endif

endmodule

// File: tb/tb_sf_tester_pattern_checker.sv
// Bench for sf_tester_pattern_checker: table runs, random runs against a pattern model,
// abort/reset sequences and a saturation run on a second, longer instance.
module tb_sf_tester_pattern_checker;

    localparam int BPP      = 256;
    localparam int PAGES    = 2;
    localparam int NBYTES   = BPP * PAGES;
    localparam int SAT_PG   = 257;
    localparam int SAT_N    = BPP * SAT_PG;
    localparam int AW       = 25;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          start_sat = 1'b0;
    logic [7:0]    pat_start = 8'd0;
    logic [7:0]    pat_incr = 8'd0;
    logic [AW-1:0] start_addr = '0;
    logic          abort = 1'b0;
    logic          rx_valid = 1'b0;
    logic          valid_sat = 1'b0;
    logic [7:0]    rx_data = 8'd0;

    logic          rx_ready, busy, done, pass;
    logic [15:0]   err_count;
    logic [AW-1:0] byte_count, fe_addr;
    logic [7:0]    fe_exp, fe_act;

    logic          s_ready, s_busy, s_done, s_pass;
    logic [15:0]   s_err;
    logic [AW-1:0] s_bc, s_fa;
    logic [7:0]    s_fe, s_fact;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sf_tester_pattern_checker #(
        .PARAM_BYTES_PER_PAGE(BPP), .PARAM_PAGE_COUNT(PAGES), .PARAM_ADDR_WIDTH(AW)
    ) dut (
        .i_clk_40mhz(clk), .i_rstn_40mhz(rst_n), .i_start(start),
        .i_pattern_start(pat_start), .i_pattern_incr(pat_incr), .i_start_addr(start_addr),
        .i_abort(abort), .i_rx_valid(rx_valid), .i_rx_data(rx_data),
        .o_rx_ready(rx_ready), .o_busy(busy), .o_done(done), .o_pass(pass),
        .o_err_count(err_count), .o_byte_count(byte_count), .o_first_err_addr(fe_addr),
        .o_first_err_expected(fe_exp), .o_first_err_actual(fe_act)
    );

    sf_tester_pattern_checker #(
        .PARAM_BYTES_PER_PAGE(BPP), .PARAM_PAGE_COUNT(SAT_PG), .PARAM_ADDR_WIDTH(AW)
    ) dut_sat (
        .i_clk_40mhz(clk), .i_rstn_40mhz(rst_n), .i_start(start_sat),
        .i_pattern_start(pat_start), .i_pattern_incr(pat_incr), .i_start_addr(start_addr),
        .i_abort(abort), .i_rx_valid(valid_sat), .i_rx_data(rx_data),
        .o_rx_ready(s_ready), .o_busy(s_busy), .o_done(s_done), .o_pass(s_pass),
        .o_err_count(s_err), .o_byte_count(s_bc), .o_first_err_addr(s_fa),
        .o_first_err_expected(s_fe), .o_first_err_actual(s_fact)
    );

    typedef struct {
        logic [7:0]    st;
        logic [7:0]    inc;
        logic [AW-1:0] addr;
        int            err_idx;
        logic [7:0]    err_val;
        logic [15:0]   exp_err;
        logic          exp_pass;
        logic [AW-1:0] exp_fa;
        logic [7:0]    exp_fe;
        logic [7:0]    exp_fact;
    } vec_t;

    vec_t tbl [5];

    // Pattern rule: page start plus increment times byte offset in page, modulo 256.
    function automatic logic [7:0] exp_at(input logic [7:0] s, input logic [7:0] inc, input int idx);
        int off;
        off = idx % BPP;
        return 8'((int'(s) + int'(inc) * off) % 256);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_first(input string tag, input logic [AW-1:0] fa,
                               input logic [7:0] fe, input logic [7:0] fact);
`ifdef SF_CHECKER_FIRST_ERR_CAPTURE_EN
        check({tag, "_first_addr"}, 32'(fe_addr), 32'(fa));
        check({tag, "_first_exp"}, 32'(fe_exp), 32'(fe));
        check({tag, "_first_act"}, 32'(fe_act), 32'(fact));
`else
        check({tag, "_first_addr"}, 32'(fe_addr), 32'(0));
        check({tag, "_first_exp"}, 32'(fe_exp), 32'(0));
        check({tag, "_first_act"}, 32'(fe_act), 32'(0));
        if (fa == '0 && fe == 8'd0 && fact == 8'd0) begin end
`endif
    endtask

    task automatic run_table(input int k, input vec_t v);
        logic  early;
        string tag;
        tag = $sformatf("vec%0d", k);
        early = 1'b0;
        start = 1'b1; pat_start = v.st; pat_incr = v.inc; start_addr = v.addr;
        tick();
        start = 1'b0;
        check({tag, "_ready"}, 32'(rx_ready), 32'(1));
        check({tag, "_busy"}, 32'(busy), 32'(1));
        for (int i = 0; i < NBYTES; i++) begin
            rx_valid = 1'b1;
            rx_data  = (i == v.err_idx) ? v.err_val : exp_at(v.st, v.inc, i);
            if (i == 200) begin
                start = 1'b1; pat_start = ~v.st; pat_incr = v.inc + 8'd1; start_addr = '0;
            end else begin
                start = 1'b0;
            end
            tick();
            if (i < NBYTES - 1 && done) early = 1'b1;
            if (i == 0) check({tag, "_bc_after_first"}, 32'(byte_count), 32'(1));
        end
        rx_valid = 1'b0;
        start = 1'b0;
        check({tag, "_early_done"}, 32'(early), 32'(0));
        check({tag, "_done"}, 32'(done), 32'(1));
        check({tag, "_ready_at_done"}, 32'(rx_ready), 32'(0));
        check({tag, "_err"}, 32'(err_count), 32'(v.exp_err));
        check({tag, "_pass"}, 32'(pass), 32'(v.exp_pass));
        check({tag, "_byte_count"}, 32'(byte_count), 32'(NBYTES));
        check_first(tag, v.exp_fa, v.exp_fe, v.exp_fact);
        tick();
        check({tag, "_done_one_cycle"}, 32'(done), 32'(0));
        check({tag, "_pass_hold"}, 32'(pass), 32'(v.exp_pass));
    endtask

    task automatic run_random(input int k);
        logic [7:0]    s, inc, d, e;
        logic [AW-1:0] addr, m_fa;
        logic [7:0]    m_fe, m_fact;
        int            idx, m_err;
        logic          early;
        string         tag;
        tag = $sformatf("rnd%0d", k);
        s = 8'($urandom); inc = 8'($urandom); addr = AW'($urandom);
        m_err = 0; m_fa = '0; m_fe = 8'd0; m_fact = 8'd0; early = 1'b0;
        start = 1'b1; pat_start = s; pat_incr = inc; start_addr = addr;
        tick();
        start = 1'b0;
        idx = 0;
        while (idx < NBYTES) begin
            rx_valid = ($urandom_range(0, 3) != 0);
            e = exp_at(s, inc, idx);
            d = ($urandom_range(0, 15) == 0) ? 8'($urandom) : e;
            rx_data = d;
            tick();
            if (rx_valid) begin
                if (d != e) begin
                    if (m_err == 0) begin
                        m_fa = addr + AW'(idx); m_fe = e; m_fact = d;
                    end
                    m_err++;
                end
                idx++;
            end
            if (idx < NBYTES && done) early = 1'b1;
        end
        rx_valid = 1'b0;
        check({tag, "_early_done"}, 32'(early), 32'(0));
        check({tag, "_done"}, 32'(done), 32'(1));
        check({tag, "_err"}, 32'(err_count), 32'(m_err));
        check({tag, "_pass"}, 32'(pass), 32'(m_err == 0));
        check({tag, "_byte_count"}, 32'(byte_count), 32'(NBYTES));
        check_first(tag, m_fa, m_fe, m_fact);
        tick();
    endtask

    initial begin
        tbl[0] = '{8'h00, 8'h01, 25'h0000000, -1,  8'h00, 16'd0, 1'b1, 25'h0000000, 8'h00, 8'h00};
        tbl[1] = '{8'h08, 8'h07, 25'h0100000, 300, 8'hFF, 16'd1, 1'b0, 25'h010012C, 8'h3C, 8'hFF};
        tbl[2] = '{8'h10, 8'h0F, 25'h0000000, -1,  8'h00, 16'd0, 1'b1, 25'h0000000, 8'h00, 8'h00};
        tbl[3] = '{8'h10, 8'h0F, 25'h0000000, 256, 8'h1F, 16'd1, 1'b0, 25'h0000100, 8'h10, 8'h1F};
        tbl[4] = '{8'h00, 8'h01, 25'h1FFFF00, 300, 8'h00, 16'd1, 1'b0, 25'h000002C, 8'h2C, 8'h00};

        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", 32'(rx_ready), 32'(0));
        check("reset_busy", 32'(busy), 32'(0));
        check("reset_done", 32'(done), 32'(0));
        check("reset_pass", 32'(pass), 32'(0));
        check("reset_err", 32'(err_count), 32'(0));
        check("reset_bc", 32'(byte_count), 32'(0));
        rst_n = 1'b1;
        tick();

        for (int k = 0; k < 5; k++) run_table(k, tbl[k]);
        for (int k = 0; k < 2; k++) run_random(k);

        // Abort after 100 bytes with three corrupted; the byte in the abort cycle is dropped.
        start = 1'b1; pat_start = 8'h00; pat_incr = 8'h01; start_addr = '0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            rx_valid = 1'b1;
            rx_data = (i == 10 || i == 20 || i == 30) ? ~exp_at(8'h00, 8'h01, i) : exp_at(8'h00, 8'h01, i);
            tick();
        end
        abort = 1'b1; rx_valid = 1'b1; rx_data = exp_at(8'h00, 8'h01, 100);
        tick();
        abort = 1'b0; rx_valid = 1'b0;
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_ready", 32'(rx_ready), 32'(0));
        check("abort_done", 32'(done), 32'(0));
        check("abort_bc", 32'(byte_count), 32'(100));
        check("abort_err", 32'(err_count), 32'(3));
        check("abort_pass", 32'(pass), 32'(0));
        tick();
        check("abort_done_later", 32'(done), 32'(0));
        check("abort_bc_frozen", 32'(byte_count), 32'(100));

        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("start_abort_busy", 32'(busy), 32'(1));
        check("start_abort_bc", 32'(byte_count), 32'(0));
        check("start_abort_err", 32'(err_count), 32'(0));
        for (int i = 0; i < 50; i++) begin
            rx_valid = 1'b1;
            rx_data = ~exp_at(8'h00, 8'h01, i);
            tick();
        end
        rx_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_busy", 32'(busy), 32'(0));
        check("rst_mid_ready", 32'(rx_ready), 32'(0));
        check("rst_mid_bc", 32'(byte_count), 32'(0));
        check("rst_mid_err", 32'(err_count), 32'(0));
        check("rst_mid_done", 32'(done), 32'(0));
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_release_done", 32'(done), 32'(0));
        check("rst_release_busy", 32'(busy), 32'(0));

        // Every byte wrong on the long instance drives the error count into saturation.
        start_sat = 1'b1; pat_start = 8'h00; pat_incr = 8'h01;
        tick();
        start_sat = 1'b0;
        for (int i = 0; i < SAT_N; i++) begin
            valid_sat = 1'b1;
            rx_data = ~exp_at(8'h00, 8'h01, i);
            tick();
        end
        valid_sat = 1'b0;
        check("sat_done", 32'(s_done), 32'(1));
        check("sat_err", 32'(s_err), 32'(16'hFFFF));
        check("sat_bc", 32'(s_bc), 32'(SAT_N));
        check("sat_pass", 32'(s_pass), 32'(0));
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
